// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - pipeline control bundle between core datapath and hazard controller
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             start_i;
    logic             IDEX_MemRead_i;
    logic [4:0]       IDEX_RDaddr_i;
    logic [4:0]       IFID_RS1addr_i;
    logic [4:0]       IFID_RS2addr_i;
    logic             IFID_UsesRS2_i;
    logic             Branch_i;
    logic             EXMEM_MemAccess_i;
    logic             DMem_ack_i;
    logic             PCWrite_o;
    logic             IFIDWrite_o;
    logic             IFIDFlush_o;
    logic             IDEXWrite_o;
    logic             IDEXBubble_o;
    logic             EXMEMWrite_o;
    logic             MEMWBBubble_o;
    logic             DMem_req_o;
    logic             Err_o;
    logic [CNT_W-1:0] StallCnt_o;
    logic [CNT_W-1:0] FlushCnt_o;

    modport master (
        output start_i, IDEX_MemRead_i, IDEX_RDaddr_i, IFID_RS1addr_i, IFID_RS2addr_i,
               IFID_UsesRS2_i, Branch_i, EXMEM_MemAccess_i, DMem_ack_i,
        input  PCWrite_o, IFIDWrite_o, IFIDFlush_o, IDEXWrite_o, IDEXBubble_o,
               EXMEMWrite_o, MEMWBBubble_o, DMem_req_o, Err_o, StallCnt_o, FlushCnt_o
    );

    modport slave (
        input  start_i, IDEX_MemRead_i, IDEX_RDaddr_i, IFID_RS1addr_i, IFID_RS2addr_i,
               IFID_UsesRS2_i, Branch_i, EXMEM_MemAccess_i, DMem_ack_i,
        output PCWrite_o, IFIDWrite_o, IFIDFlush_o, IDEXWrite_o, IDEXBubble_o,
               EXMEMWrite_o, MEMWBBubble_o, DMem_req_o, Err_o, StallCnt_o, FlushCnt_o
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - 5-stage pipeline stall/flush sequencer with memory-wait freeze and timeout trap
module pipe_hazard_ctrl #(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    pipe_hazard_ctrl_if.slave bus
);
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2,
        ERROR    = 2'd3
    } state_t;

    state_t             state, state_nx;
    logic [WAIT_W-1:0]  wait_cnt, wait_cnt_nx;
    logic [CNT_W-1:0]   stall_cnt, flush_cnt;
    logic               hz_lu, hz_mem;
    logic               pc_write, ifid_write, ifid_flush, idex_write, idex_bubble;
    logic               exmem_write, memwb_bubble, dmem_req;

    assign hz_lu = bus.IDEX_MemRead_i && (bus.IDEX_RDaddr_i != 5'd0) &&
                   ((bus.IDEX_RDaddr_i == bus.IFID_RS1addr_i) ||
                    (bus.IFID_UsesRS2_i && (bus.IDEX_RDaddr_i == bus.IFID_RS2addr_i)));
    assign hz_mem = bus.EXMEM_MemAccess_i && !bus.DMem_ack_i;

    always_comb begin
        state_nx     = state;
        wait_cnt_nx  = wait_cnt;
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        ifid_flush   = 1'b0;
        idex_write   = 1'b1;
        idex_bubble  = 1'b0;
        exmem_write  = 1'b1;
        memwb_bubble = 1'b0;
        dmem_req     = 1'b0;
        case (state)
            IDLE: begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_bubble = 1'b1;
                if (bus.start_i) state_nx = RUN;
            end
            RUN: begin
                dmem_req = bus.EXMEM_MemAccess_i;
                if (hz_mem) begin
                    pc_write     = 1'b0;
                    ifid_write   = 1'b0;
                    idex_write   = 1'b0;
                    exmem_write  = 1'b0;
                    memwb_bubble = 1'b1;
                    wait_cnt_nx  = '0;
                    state_nx     = MEM_WAIT;
                end else if (hz_lu) begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                end else if (bus.Branch_i) begin
                    ifid_flush = 1'b1;
                end
            end
            MEM_WAIT: begin
                dmem_req = 1'b1;
                if (!bus.DMem_ack_i) begin
                    pc_write     = 1'b0;
                    ifid_write   = 1'b0;
                    idex_write   = 1'b0;
                    exmem_write  = 1'b0;
                    memwb_bubble = 1'b1;
                    // Count this no-ack cycle; trap once MEM_TIMEOUT of them have elapsed
                    if (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) begin
                        state_nx = ERROR;
                    end else begin
                        wait_cnt_nx = wait_cnt + 1'b1;
                    end
                end else begin
                    state_nx = RUN;
                    if (hz_lu) begin
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_bubble = 1'b1;
                    end else if (bus.Branch_i) begin
                        ifid_flush = 1'b1;
                    end
                end
            end
            default: begin
                pc_write     = 1'b0;
                ifid_write   = 1'b0;
                idex_write   = 1'b0;
                exmem_write  = 1'b0;
                idex_bubble  = 1'b1;
                memwb_bubble = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state    <= state_nx;
            wait_cnt <= wait_cnt_nx;
            if (((state == RUN) || (state == MEM_WAIT)) && !pc_write && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (ifid_flush && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

    assign bus.PCWrite_o     = pc_write;
    assign bus.IFIDWrite_o   = ifid_write;
    assign bus.IFIDFlush_o   = ifid_flush;
    assign bus.IDEXWrite_o   = idex_write;
    assign bus.IDEXBubble_o  = idex_bubble;
    assign bus.EXMEMWrite_o  = exmem_write;
    assign bus.MEMWBBubble_o = memwb_bubble;
    assign bus.DMem_req_o    = dmem_req;
    assign bus.Err_o         = (state == ERROR);
    assign bus.StallCnt_o    = stall_cnt;
    assign bus.FlushCnt_o    = flush_cnt;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed checks of pipe_hazard_ctrl stalls, flushes, memory freeze and timeout
module tb_pipe_hazard_ctrl;
    localparam int CNT_W = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipe_hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(4)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clr();
        bus.start_i           = 1'b0;
        bus.IDEX_MemRead_i    = 1'b0;
        bus.IDEX_RDaddr_i     = 5'd0;
        bus.IFID_RS1addr_i    = 5'd0;
        bus.IFID_RS2addr_i    = 5'd0;
        bus.IFID_UsesRS2_i    = 1'b0;
        bus.Branch_i          = 1'b0;
        bus.EXMEM_MemAccess_i = 1'b0;
        bus.DMem_ack_i        = 1'b0;
    endtask

    // advance one clock edge and land mid-low-phase, then settle
    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [7:0] enables();
        return {bus.PCWrite_o, bus.IFIDWrite_o, bus.IFIDFlush_o, bus.IDEXWrite_o,
                bus.IDEXBubble_o, bus.EXMEMWrite_o, bus.MEMWBBubble_o, bus.DMem_req_o};
    endfunction

    // enables(): {PCW, IFIDW, IFIDF, IDEXW, IDEXB, EXMEMW, MEMWBB, REQ}
    initial begin
        clr();
        @(negedge clk);
        #1;
        check("reset_idle_ctl", enables(), 8'b0001_1100);
        check("reset_err", bus.Err_o, 0);
        check("reset_stall", bus.StallCnt_o, 0);
        check("reset_flush", bus.FlushCnt_o, 0);
        rst = 1'b1;
        cyc();
        check("idle_c1", enables(), 8'b0001_1100);
        cyc();
        bus.start_i = 1'b1;
        #1;
        check("idle_c2_start", bus.PCWrite_o, 0);
        cyc();
        bus.start_i = 1'b0;
        #1;
        check("run_pcwrite", enables(), 8'b1101_0100);
        check("run_stall0", bus.StallCnt_o, 0);

        // load-use on rs1
        bus.IDEX_MemRead_i = 1'b1; bus.IDEX_RDaddr_i = 5'd5; bus.IFID_RS1addr_i = 5'd5;
        #1;
        check("lu_ctl", enables(), 8'b0001_1100);
        cyc();
        clr();
        #1;
        check("lu_stall1", bus.StallCnt_o, 1);
        check("lu_release", bus.PCWrite_o, 1);

        // rd=0 never hazards
        bus.IDEX_MemRead_i = 1'b1; bus.IDEX_RDaddr_i = 5'd0; bus.IFID_RS1addr_i = 5'd0;
        #1;
        check("lu_rd0", bus.PCWrite_o, 1);
        cyc();
        check("lu_rd0_cnt", bus.StallCnt_o, 1);

        // rs2 match only matters when rs2 is used
        bus.IDEX_RDaddr_i = 5'd5; bus.IFID_RS1addr_i = 5'd1; bus.IFID_RS2addr_i = 5'd5;
        #1;
        check("lu_rs2_unused", bus.PCWrite_o, 1);
        bus.IFID_UsesRS2_i = 1'b1;
        #1;
        check("lu_rs2_used", bus.PCWrite_o, 0);
        cyc();
        clr();
        #1;
        check("lu_rs2_cnt", bus.StallCnt_o, 2);

        // branch alone
        bus.Branch_i = 1'b1;
        #1;
        check("br_ctl", enables(), 8'b1111_0100);
        cyc();
        bus.Branch_i = 1'b0;
        #1;
        check("br_cnt", bus.FlushCnt_o, 1);
        check("br_done", bus.IFIDFlush_o, 0);

        // branch with load-use: stall wins, branch flushes next cycle
        bus.Branch_i = 1'b1; bus.IDEX_MemRead_i = 1'b1; bus.IDEX_RDaddr_i = 5'd7; bus.IFID_RS1addr_i = 5'd7;
        #1;
        check("br_lu_ctl", enables(), 8'b0001_1100);
        cyc();
        bus.IDEX_MemRead_i = 1'b0;
        #1;
        check("br_lu_stall", bus.StallCnt_o, 3);
        check("br_lu_flushcnt0", bus.FlushCnt_o, 1);
        check("br_after_lu", bus.IFIDFlush_o, 1);
        cyc();
        clr();
        #1;
        check("br_after_lu_cnt", bus.FlushCnt_o, 2);

        // memory access, ack three cycles after request, branch ignored in freeze
        bus.EXMEM_MemAccess_i = 1'b1; bus.Branch_i = 1'b1;
        #1;
        check("mem_freeze0", enables(), 8'b0000_0011);
        cyc();
        bus.Branch_i = 1'b0;
        #1;
        check("mem_freeze1", enables(), 8'b0000_0011);
        cyc();
        check("mem_freeze2", enables(), 8'b0000_0011);
        cyc();
        bus.DMem_ack_i = 1'b1; bus.Branch_i = 1'b1;
        #1;
        check("mem_release", enables(), 8'b1111_0101);
        check("mem_flush_cnt_hold", bus.FlushCnt_o, 2);
        cyc();
        bus.Branch_i = 1'b0;
        #1;
        check("mem_stall3", bus.StallCnt_o, 6);
        check("mem_flush_cnt", bus.FlushCnt_o, 3);
        check("mem_imm_ack", enables(), 8'b1101_0101);
        cyc();
        clr();
        #1;
        check("mem_imm_stall0", bus.StallCnt_o, 6);

        // timeout: request stall + 4 no-ack wait cycles, then ERROR
        bus.EXMEM_MemAccess_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("to_wait%0d", i), {bus.Err_o, bus.PCWrite_o, bus.DMem_req_o}, 3'b001);
            cyc();
        end
        check("to_err", bus.Err_o, 1);
        check("to_err_ctl", enables(), 8'b0000_1010);
        check("to_stall", bus.StallCnt_o, 11);
        bus.start_i = 1'b1; bus.DMem_ack_i = 1'b1;
        cyc();
        cyc();
        check("to_err_hold", bus.Err_o, 1);
        check("to_stall_hold", bus.StallCnt_o, 11);

        // reset leaves ERROR
        rst = 1'b0;
        #1;
        check("rst_err_clr", bus.Err_o, 0);
        check("rst_idle_ctl", enables(), 8'b0001_1100);
        check("rst_cnt_clr", {bus.StallCnt_o, bus.FlushCnt_o}, 0);
        clr();
        cyc();
        rst = 1'b1;
        bus.start_i = 1'b1;
        cyc();
        bus.start_i = 1'b0; bus.EXMEM_MemAccess_i = 1'b1;
        cyc();
        check("mw_req", bus.DMem_req_o, 1);
        // asynchronous reset mid-MEM_WAIT
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("mw_abort_req", bus.DMem_req_o, 0);
        check("mw_abort_idle", enables(), 8'b0001_1100);
        cyc();
        check("mw_abort_hold", bus.DMem_req_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline sequencing controller for the 5-stage RISC-V core. It drives the write-enable, bubble and flush controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It detects load-use hazards and taken-branch flushes, and freezes the pipeline during multi-cycle data-memory accesses. It also keeps saturating stall and flush statistics and traps on a data-memory timeout.

## Interface
- CNT_W, 16, width of the statistics counters
- MEM_TIMEOUT, 255, maximum number of MEM_WAIT cycles before the block traps to ERROR
- clk_i  in  1  system clock; all state updates on the rising edge
- rst_i  in  1  asynchronous reset, active-low
- start_i  in  1  level input; releases the core from IDLE
- IDEX_MemRead_i  in  1  the instruction in EX is a load
- IDEX_RDaddr_i  in  5  destination register of the instruction in EX
- IFID_RS1addr_i  in  5  rs1 of the instruction in ID
- IFID_RS2addr_i  in  5  rs2 of the instruction in ID
- IFID_UsesRS2_i  in  1  the instruction in ID reads rs2
- Branch_i  in  1  branch resolved taken in ID this cycle
- EXMEM_MemAccess_i  in  1  the instruction in MEM is a load or store
- DMem_ack_i  in  1  data memory completes the access this cycle
- PCWrite_o  out  1  PC load enable
- IFIDWrite_o  out  1  IF/ID load enable
- IFIDFlush_o  out  1  IF/ID loads a NOP
- IDEXWrite_o  out  1  ID/EX load enable
- IDEXBubble_o  out  1  ID/EX loads zeroed WB/MEM/EX control
- EXMEMWrite_o  out  1  EX/MEM load enable
- MEMWBBubble_o  out  1  MEM/WB loads zeroed WB control
- DMem_req_o  out  1  data memory request
- Err_o  out  1  timeout trap flag
- StallCnt_o  out  CNT_W  count of stall cycles
- FlushCnt_o  out  CNT_W  count of branch flushes

## Operation
- States: IDLE, RUN, MEM_WAIT, ERROR. The state and counters are registered. Control outputs are a combinational (Mealy) decode of the state and the current inputs.
- Hazard definitions:
  - hz_lu = IDEX_MemRead_i and IDEX_RDaddr_i != 0 and (IDEX_RDaddr_i == IFID_RS1addr_i or (IFID_UsesRS2_i and IDEX_RDaddr_i == IFID_RS2addr_i)).
  - hz_mem = EXMEM_MemAccess_i and not DMem_ack_i.
- IDLE:
  - Outputs: PCWrite=0, IFIDWrite=0, IFIDFlush=0, IDEXWrite=1, IDEXBubble=1, EXMEMWrite=1, MEMWBBubble=0, DMem_req=0.
  - start_i=1 moves to RUN.
- RUN defaults: all write enables 1, bubbles and flush 0. DMem_req_o = EXMEM_MemAccess_i.
- RUN priority 1, hz_mem:
  - PCWrite=0, IFIDWrite=0, IDEXWrite=0, EXMEMWrite=0, MEMWBBubble=1.
  - Move to MEM_WAIT and clear wait_cnt.
  - hz_lu and Branch_i are ignored that cycle.
- RUN priority 2, hz_lu:
  - PCWrite=0, IFIDWrite=0, IDEXBubble=1.
  - Branch_i is ignored. The branch is re-evaluated the next cycle while the branch instruction is still in ID.
- RUN priority 3, Branch_i:
  - IFIDFlush=1. PC loads the target, supplied externally.
- MEM_WAIT:
  - DMem_req=1. While DMem_ack_i=0, the freeze outputs of RUN priority 1 apply and wait_cnt increments.
  - DMem_ack_i=1: that same cycle all enables are 1, MEMWBBubble=0, and ID-stage hazards are evaluated as in RUN priorities 2–3. Move to RUN.
  - wait_cnt reaching MEM_TIMEOUT with no ack: move to ERROR.
- ERROR:
  - All write enables 0, IDEXBubble=1, MEMWBBubble=1, DMem_req=0, Err_o=1.
  - Exit only by reset. start_i is ignored.
- StallCnt_o increments each cycle in RUN or MEM_WAIT with PCWrite_o=0.
- FlushCnt_o increments each cycle with IFIDFlush_o=1.
- Both counters saturate at 2^CNT_W−1. They are never cleared except by reset.

## Timing
- Reset (rst_i low, asynchronous): state=IDLE, wait_cnt=0, StallCnt_o=0, FlushCnt_o=0, Err_o=0. Outputs equal the IDLE decode.
- Reset asserted mid-MEM_WAIT aborts immediately. No request is held afterwards.
- start_i sampled high at edge N puts the block in RUN from cycle N+1. PC first advances at edge N+1.
- A load-use stall lasts exactly 1 cycle. At the next edge the load leaves EX, so hz_lu clears.
- Memory access with ack in the cycle of the request: zero stall cycles.
- Memory access with ack k cycles later: exactly k stall cycles, and StallCnt_o increases by k.
- The timeout fires after MEM_TIMEOUT consecutive no-ack cycles in MEM_WAIT. ERROR is visible at the following edge.
- Simultaneous events:
  - hz_mem with Branch_i: no flush and no FlushCnt increment.
  - ack with Branch_i in the release cycle: flush occurs.
- Counter outputs update on the clock edge after the qualifying cycle.

## Test plan
- Reset, then start_i=1 at cycle 2 → IDLE outputs at cycle 0–2; PCWrite_o=1 from cycle 3; counters 0.
- Load-use hazard, IDEX_MemRead_i=1, rd=5, rs1=5 → one cycle with PCWrite=0, IFIDWrite=0, IDEXBubble=1; StallCnt 0→1.
- Repeat the previous case with rd=0 → no stall.
- Repeat with rd=5, rs2=5, UsesRS2=0 → no stall.
- Branch_i=1 alone → IFIDFlush_o=1 for 1 cycle; FlushCnt=1.
- Branch_i and hz_lu together → stall only, no flush. Branch held the next cycle → flush; FlushCnt=1.
- EXMEM_MemAccess_i=1 with DMem_ack_i rising after 3 cycles → 3 frozen cycles with MEMWBBubble=1; release on the ack cycle; StallCnt=3. An immediate ack gives 0 stall.
- MEM_TIMEOUT=4, ack never asserted → ERROR after 4 wait cycles with Err_o=1 and all enables 0. Holds until rst_i low, which returns to IDLE.
